// File: rtl/aq_axi_sdma64_pkg.sv
// Shared FSM encoding and AXI constants for the 64-bit simple DMA write engine.
package aq_axi_sdma64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  localparam logic [2:0]  AXSIZE_64   = 3'b011;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [7:0]  WSTRB_ALL   = 8'hFF;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/aq_axi_sdma64_blen.sv
// Burst-length calculator: min(remaining beats, MAX_BURST, beats left before the next 4 KB page).
module aq_axi_sdma64_blen
  import aq_axi_sdma64_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [11:3] cur_addr_i,
  input  logic [31:0] remain_i,
  output logic [8:0]  blen_o
);

  logic [9:0]  beats4k;
  logic [32:0] beats4k33;
  logic [32:0] remain33;
  logic [32:0] maxBurst33;
  logic [32:0] minA;
  logic [32:0] minB;

  // Address is always 8-byte aligned, so the page distance is counted in beats directly.
  always_comb begin
    beats4k    = 10'(BOUNDARY_4K >> 3) - {1'b0, cur_addr_i};
    beats4k33  = {23'b0, beats4k};
    remain33   = {1'b0, remain_i};
    maxBurst33 = 33'(MAX_BURST);
    minA       = (remain33 < maxBurst33) ? remain33 : maxBurst33;
    minB       = (minA < beats4k33) ? minA : beats4k33;
    blen_o     = 9'(minB);
  end

endmodule

// File: rtl/aq_axi_sdma64_wburst.sv
// Write-side drain engine: pops a FWFT FIFO and emits 4 KB-safe AXI4 INCR write bursts.
module aq_axi_sdma64_wburst
  import aq_axi_sdma64_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [31:0]       CMD_LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              FIFO_RD_ENA,
  input  logic [64:0]       FIFO_RD_DATA,
  input  logic              FIFO_RD_EMPTY,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [63:0]       M_AXI_WDATA,
  output logic [7:0]        M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [ADDR_W-1:0] awAddr_q, awAddr_d;
  logic [31:0]       remain_q, remain_d;
  logic [8:0]        blen_q, blen_d;
  logic [8:0]        beat_q, beat_d;
  logic [7:0]        awLen_q, awLen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [8:0]        blenCalc;
  logic              wValid;
  logic              wHandshake;
  logic              unusedFifoBit;

  aq_axi_sdma64_blen #(
    .MAX_BURST(MAX_BURST)
  ) u_blen (
    .cur_addr_i(curAddr_q[11:3]),
    .remain_i  (remain_q),
    .blen_o    (blenCalc)
  );

  assign unusedFifoBit = FIFO_RD_DATA[64];

  assign wValid     = (state_q == ST_W) & ~FIFO_RD_EMPTY;
  assign wHandshake = wValid & M_AXI_WREADY;

  assign CMD_READY     = (state_q == ST_IDLE);
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign FIFO_RD_ENA   = wHandshake;
  assign M_AXI_AWADDR  = awAddr_q;
  assign M_AXI_AWLEN   = awLen_q;
  assign M_AXI_AWSIZE  = AXSIZE_64;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWVALID = (state_q == ST_AW);
  assign M_AXI_WDATA   = FIFO_RD_DATA[63:0];
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_WLAST   = (beat_q == 9'd1) & wValid;
  assign M_AXI_WVALID  = wValid;
  assign M_AXI_BREADY  = (state_q == ST_B);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only one burst is ever in flight: the next AW is computed after the previous B.
  always_comb begin
    state_d   = state_q;
    curAddr_d = curAddr_q;
    awAddr_d  = awAddr_q;
    remain_d  = remain_q;
    blen_d    = blen_q;
    beat_d    = beat_q;
    awLen_d   = awLen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          curAddr_d = {CMD_ADDR[ADDR_W-1:3], 3'b000};
          remain_d  = CMD_LEN;
          err_d     = 1'b0;
          if (CMD_LEN == 32'd0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        blen_d   = blenCalc;
        awAddr_d = curAddr_q;
        awLen_d  = 8'(blenCalc - 9'd1);
        state_d  = ST_AW;
      end
      ST_AW: begin
        if (M_AXI_AWREADY) begin
          beat_d  = blen_q;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (wHandshake) begin
          beat_d = beat_q - 9'd1;
          if (beat_q == 9'd1) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_d = 1'b1;
          end
          curAddr_d = curAddr_q + {{(ADDR_W-12){1'b0}}, blen_q, 3'b000};
          remain_d  = remain_q - {23'b0, blen_q};
          if (remain_q == {23'b0, blen_q}) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      curAddr_q <= '0;
      awAddr_q  <= '0;
      remain_q  <= '0;
      blen_q    <= '0;
      beat_q    <= '0;
      awLen_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      curAddr_q <= curAddr_d;
      awAddr_q  <= awAddr_d;
      remain_q  <= remain_d;
      blen_q    <= blen_d;
      beat_q    <= beat_d;
      awLen_q   <= awLen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_aq_axi_sdma64_wburst.sv
// Directed self-checking bench for aq_axi_sdma64_wburst with a FWFT FIFO and AXI slave model.
module tb_aq_axi_sdma64_wburst;

  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 16;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              CMD_VALID = 1'b0;
  logic              CMD_READY;
  logic [ADDR_W-1:0] CMD_ADDR = '0;
  logic [31:0]       CMD_LEN = '0;
  logic              BUSY, DONE, ERR;
  logic              FIFO_RD_ENA;
  logic [64:0]       FIFO_RD_DATA;
  logic              FIFO_RD_EMPTY;
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [7:0]        M_AXI_AWLEN;
  logic [2:0]        M_AXI_AWSIZE;
  logic [1:0]        M_AXI_AWBURST;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY = 1'b1;
  logic [63:0]       M_AXI_WDATA;
  logic [7:0]        M_AXI_WSTRB;
  logic              M_AXI_WLAST, M_AXI_WVALID;
  logic              M_AXI_WREADY = 1'b1;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;

  always #5 CLK = ~CLK;

  aq_axi_sdma64_wburst #(
    .MAX_BURST(MAX_BURST),
    .ADDR_W   (ADDR_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .FIFO_RD_ENA(FIFO_RD_ENA), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_EMPTY(FIFO_RD_EMPTY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // FWFT FIFO model; flushed by the shared reset.
  logic [64:0] fifoMem [0:255];
  int wrPtr = 0;
  int rdPtr = 0;
  int pushSeq = 0;
  assign FIFO_RD_EMPTY = (rdPtr == wrPtr);
  assign FIFO_RD_DATA  = fifoMem[rdPtr[7:0]];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rdPtr <= wrPtr;
    else if (FIFO_RD_ENA) rdPtr <= rdPtr + 1;
  end

  // B channel responder: one response per WLAST, error injected on a chosen burst.
  logic bPending;
  int   bCount = 0;
  int   errBurstIdx = -1;
  assign M_AXI_BVALID = bPending;
  assign M_AXI_BRESP  = (bCount == errBurstIdx) ? 2'b10 : 2'b00;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bPending <= 1'b0;
    else if (M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST) bPending <= 1'b1;
    else if (M_AXI_BVALID && M_AXI_BREADY) bPending <= 1'b0;
  end

  // Protocol monitor and transaction logs (cumulative across tests).
  int          awCount = 0;
  int          wCount = 0;
  int          doneCount = 0;
  int          violations = 0;
  logic        outstanding = 1'b0;
  logic [31:0] awAddrLog [0:63];
  logic [7:0]  awLenLog  [0:63];
  logic [63:0] wDataLog  [0:255];
  logic        wLastLog  [0:255];

  always @(posedge CLK) begin
    if (!RST_N) begin
      outstanding <= 1'b0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        awAddrLog[awCount[5:0]] <= M_AXI_AWADDR;
        awLenLog[awCount[5:0]]  <= M_AXI_AWLEN;
        awCount <= awCount + 1;
        if (outstanding) violations = violations + 1;
        if ((int'(M_AXI_AWADDR[11:0]) + (int'(M_AXI_AWLEN) + 1) * 8) > 4096) violations = violations + 1;
        outstanding <= 1'b1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        wDataLog[wCount[7:0]] <= M_AXI_WDATA;
        wLastLog[wCount[7:0]] <= M_AXI_WLAST;
        wCount <= wCount + 1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        bCount <= bCount + 1;
        outstanding <= 1'b0;
      end
      if (DONE) begin
        doneCount <= doneCount + 1;
        if (BUSY) violations = violations + 1;
      end
      if (FIFO_RD_ENA && FIFO_RD_EMPTY) violations = violations + 1;
      if (FIFO_RD_ENA != (M_AXI_WVALID && M_AXI_WREADY)) violations = violations + 1;
    end
  end

  function automatic logic [64:0] word(input int k);
    return {k[0], 32'h5A5A_0000 + 32'(k), 32'(k * 3 + 1)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr[7:0]] = word(pushSeq);
      wrPtr++;
      pushSeq++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
    logic accepted;
    int   n;
    accepted  = 1'b0;
    n         = 0;
    CMD_ADDR  = addr;
    CMD_LEN   = len;
    CMD_VALID = 1'b1;
    while (!accepted && n < 20) begin
      @(posedge CLK);
      accepted = CMD_READY;
      n++;
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    checkOutput("cmd_accept", {63'b0, accepted}, 64'd1);
  endtask

  task automatic waitDone(input string tag, input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, "_done"}, {63'b0, doneCount >= target}, 64'd1);
  endtask

  task automatic checkData(input string tag, input int w0, input int p0, input int n);
    logic [64:0] ew;
    for (int j = 0; j < n; j++) begin
      ew = word(p0 + j);
      checkOutput($sformatf("%s_wdata%0d", tag, j), wDataLog[(w0 + j) % 256], ew[63:0]);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, {63'b0, CMD_READY}, 64'd1);
    checkOutput({tag, "_busy"}, {63'b0, BUSY}, 64'd0);
    checkOutput({tag, "_done"}, {63'b0, DONE}, 64'd0);
    checkOutput({tag, "_err"}, {63'b0, ERR}, 64'd0);
    checkOutput({tag, "_awvalid"}, {63'b0, M_AXI_AWVALID}, 64'd0);
    checkOutput({tag, "_wvalid"}, {63'b0, M_AXI_WVALID}, 64'd0);
    checkOutput({tag, "_bready"}, {63'b0, M_AXI_BREADY}, 64'd0);
    checkOutput({tag, "_wlast"}, {63'b0, M_AXI_WLAST}, 64'd0);
    checkOutput({tag, "_rd_ena"}, {63'b0, FIFO_RD_ENA}, 64'd0);
    checkOutput({tag, "_awaddr"}, 64'(M_AXI_AWADDR), 64'd0);
    checkOutput({tag, "_awlen"}, 64'(M_AXI_AWLEN), 64'd0);
  endtask

  initial begin
    int aw0, w0, p0, d0, n;

    repeat (3) @(negedge CLK);
    checkResetValues("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("awsize", 64'(M_AXI_AWSIZE), 64'd3);
    checkOutput("awburst", 64'(M_AXI_AWBURST), 64'd1);
    checkOutput("wstrb", 64'(M_AXI_WSTRB), 64'hFF);

    // Single 4-beat burst
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    pushWords(4);
    applyStimulus(32'h1000, 32'd4);
    checkOutput("t1_busy", {63'b0, BUSY}, 64'd1);
    checkOutput("t1_cmd_ready", {63'b0, CMD_READY}, 64'd0);
    @(negedge CLK);
    checkOutput("t1_awvalid", {63'b0, M_AXI_AWVALID}, 64'd1);
    checkOutput("t1_awaddr_live", 64'(M_AXI_AWADDR), 64'h1000);
    waitDone("t1", d0 + 1);
    checkOutput("t1_aw_count", 64'(awCount - aw0), 64'd1);
    checkOutput("t1_awaddr", 64'(awAddrLog[aw0]), 64'h1000);
    checkOutput("t1_awlen", 64'(awLenLog[aw0]), 64'd3);
    checkOutput("t1_w_count", 64'(wCount - w0), 64'd4);
    checkData("t1", w0, p0, 4);
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("t1_wlast%0d", j), {63'b0, wLastLog[w0 + j]}, (j == 3) ? 64'd1 : 64'd0);
    checkOutput("t1_err", {63'b0, ERR}, 64'd0);
    checkOutput("t1_busy_end", {63'b0, BUSY}, 64'd0);

    // 40 beats split 16/16/8
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    pushWords(40);
    applyStimulus(32'h0, 32'd40);
    waitDone("t2", d0 + 1);
    checkOutput("t2_aw_count", 64'(awCount - aw0), 64'd3);
    checkOutput("t2_awaddr0", 64'(awAddrLog[aw0]), 64'h000);
    checkOutput("t2_awlen0", 64'(awLenLog[aw0]), 64'd15);
    checkOutput("t2_awaddr1", 64'(awAddrLog[aw0 + 1]), 64'h080);
    checkOutput("t2_awlen1", 64'(awLenLog[aw0 + 1]), 64'd15);
    checkOutput("t2_awaddr2", 64'(awAddrLog[aw0 + 2]), 64'h100);
    checkOutput("t2_awlen2", 64'(awLenLog[aw0 + 2]), 64'd7);
    checkOutput("t2_w_count", 64'(wCount - w0), 64'd40);
    checkData("t2", w0, p0, 40);
    checkOutput("t2_wlast15", {63'b0, wLastLog[w0 + 15]}, 64'd1);
    checkOutput("t2_wlast31", {63'b0, wLastLog[w0 + 31]}, 64'd1);
    checkOutput("t2_wlast39", {63'b0, wLastLog[w0 + 39]}, 64'd1);
    checkOutput("t2_wlast20", {63'b0, wLastLog[w0 + 20]}, 64'd0);
    repeat (3) @(negedge CLK);
    checkOutput("t2_single_done", 64'(doneCount - d0), 64'd1);

    // 4 KB boundary split, unaligned low bits dropped
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    pushWords(4);
    applyStimulus(32'h0FF5, 32'd4);
    waitDone("t3", d0 + 1);
    checkOutput("t3_aw_count", 64'(awCount - aw0), 64'd2);
    checkOutput("t3_awaddr0", 64'(awAddrLog[aw0]), 64'h0FF0);
    checkOutput("t3_awlen0", 64'(awLenLog[aw0]), 64'd1);
    checkOutput("t3_awaddr1", 64'(awAddrLog[aw0 + 1]), 64'h1000);
    checkOutput("t3_awlen1", 64'(awLenLog[aw0 + 1]), 64'd1);
    checkData("t3", w0, p0, 4);

    // FIFO runs dry mid-burst for 5 cycles
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    pushWords(2);
    applyStimulus(32'h2000, 32'd6);
    n = 0;
    while (wCount - w0 < 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("t4_reach_gap", 64'(wCount - w0), 64'd2);
    for (int j = 0; j < 5; j++) begin
      checkOutput($sformatf("t4_gap_wvalid%0d", j), {63'b0, M_AXI_WVALID}, 64'd0);
      checkOutput($sformatf("t4_gap_rd_ena%0d", j), {63'b0, FIFO_RD_ENA}, 64'd0);
      @(negedge CLK);
    end
    checkOutput("t4_gap_no_bready", {63'b0, M_AXI_BREADY}, 64'd0);
    pushWords(4);
    waitDone("t4", d0 + 1);
    checkOutput("t4_aw_count", 64'(awCount - aw0), 64'd1);
    checkOutput("t4_awlen", 64'(awLenLog[aw0]), 64'd5);
    checkOutput("t4_w_count", 64'(wCount - w0), 64'd6);
    checkData("t4", w0, p0, 6);
    checkOutput("t4_wlast5", {63'b0, wLastLog[w0 + 5]}, 64'd1);

    // SLVERR on first burst of two
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    errBurstIdx = bCount;
    pushWords(24);
    applyStimulus(32'h3000, 32'd24);
    waitDone("t5", d0 + 1);
    errBurstIdx = -1;
    checkOutput("t5_aw_count", 64'(awCount - aw0), 64'd2);
    checkOutput("t5_awaddr1", 64'(awAddrLog[aw0 + 1]), 64'h3080);
    checkOutput("t5_awlen1", 64'(awLenLog[aw0 + 1]), 64'd7);
    checkOutput("t5_err", {63'b0, ERR}, 64'd1);
    repeat (3) @(negedge CLK);
    checkOutput("t5_err_sticky", {63'b0, ERR}, 64'd1);
    checkOutput("t5_done_count", 64'(doneCount - d0), 64'd1);

    // Zero-length command
    aw0 = awCount; d0 = doneCount;
    applyStimulus(32'h3100, 32'd0);
    checkOutput("t6_done", {63'b0, DONE}, 64'd1);
    checkOutput("t6_busy", {63'b0, BUSY}, 64'd0);
    checkOutput("t6_err_cleared", {63'b0, ERR}, 64'd0);
    checkOutput("t6_cmd_ready", {63'b0, CMD_READY}, 64'd1);
    @(negedge CLK);
    checkOutput("t6_done_pulse", {63'b0, DONE}, 64'd0);
    repeat (4) @(negedge CLK);
    checkOutput("t6_no_aw", 64'(awCount - aw0), 64'd0);
    checkOutput("t6_done_count", 64'(doneCount - d0), 64'd1);

    // Reset asserted while stalled in W
    M_AXI_WREADY = 1'b0;
    pushWords(4);
    applyStimulus(32'h4000, 32'd8);
    n = 0;
    while (!M_AXI_WVALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("t7_in_w", {63'b0, M_AXI_WVALID}, 64'd1);
    RST_N = 1'b0;
    #1;
    checkResetValues("t7_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    M_AXI_WREADY = 1'b1;
    @(negedge CLK);
    checkOutput("t7_cmd_ready", {63'b0, CMD_READY}, 64'd1);
    checkOutput("t7_busy", {63'b0, BUSY}, 64'd0);

    // Clean transfer after the mid-burst reset
    aw0 = awCount; w0 = wCount; p0 = pushSeq; d0 = doneCount;
    pushWords(2);
    applyStimulus(32'h5008, 32'd2);
    waitDone("t8", d0 + 1);
    checkOutput("t8_awaddr", 64'(awAddrLog[aw0]), 64'h5008);
    checkOutput("t8_awlen", 64'(awLenLog[aw0]), 64'd1);
    checkData("t8", w0, p0, 2);

    checkOutput("protocol_violations", 64'(violations), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aq_axi_sdma64_wburst.md
Name: aq_axi_sdma64_wburst

Overview:
Write-side drain engine for the 64-bit simple DMA. It takes a destination command (address plus beat count) and pops 65-bit words from a first-word-fall-through FIFO. It emits AXI4 INCR write bursts on AW/W/B and reports done and error status. It sits at the FIFO read port and is the counterpart of the AXI read engine that fills the FIFO.

Parameters:
MAX_BURST, 16, maximum beats per burst (power of two, 1..256)
ADDR_W, 32, AXI address width

Ports:
CLK  in  1  single clock for every interface
RST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command strobe
CMD_READY  out  1  high only in IDLE
CMD_ADDR  in  ADDR_W  destination byte address; bits [2:0] forced to 0
CMD_LEN  in  32  transfer length in 8-byte beats
BUSY  out  1  high from command accept until DONE
DONE  out  1  one-cycle pulse when the final B response is accepted
ERR  out  1  sticky; set on any BRESP!=OKAY, cleared on the next command accept
FIFO_RD_ENA  out  1  pop strobe = WVALID & WREADY
FIFO_RD_DATA  in  65  FWFT data; [63:0] becomes WDATA, bit 64 reserved and ignored
FIFO_RD_EMPTY  in  1  FIFO empty
M_AXI_AWADDR  out  ADDR_W
M_AXI_AWLEN  out  8  beats-1
M_AXI_AWSIZE  out  3  constant 3'b011
M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  64  = FIFO_RD_DATA[63:0]
M_AXI_WSTRB  out  8  constant 8'hFF
M_AXI_WLAST  out  1
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0 except CMD_READY=1; DONE=0, BUSY=0, ERR=0, AWADDR=0, AWLEN=0, WLAST=0; FSM in IDLE.
- FSM states: IDLE, CALC, AW, W, B.
- IDLE: CMD_VALID&CMD_READY latches addr (low 3 bits zeroed) into cur_addr and CMD_LEN into remain, clears ERR, sets BUSY. Next state is CALC. If CMD_LEN=0, the next state is IDLE instead, with DONE pulsed the following cycle and no AXI traffic.
- CALC (1 cycle): beats_4k = (4096 - cur_addr[11:0]) >> 3. Compute blen = min(remain, MAX_BURST, beats_4k), using 33-bit compare arithmetic. Register AWADDR=cur_addr and AWLEN=blen-1. Go to AW.
- AW: hold AWVALID=1 with address and length stable until AWREADY; then go to W with beat counter = blen.
- W: WVALID = ~FIFO_RD_EMPTY. WLAST = (beat counter==1) & WVALID. Each handshake pops the FIFO and decrements the counter. An empty FIFO inserts bubbles and never drops or duplicates data. After the handshake with WLAST, go to B.
- B: BREADY=1. On BVALID, set ERR if BRESP!=0, continue regardless, advance cur_addr += blen*8 and remain -= blen.
- B exit: if remain==0, go to IDLE and pulse DONE, with BUSY falling the same cycle DONE pulses. Otherwise go to CALC.
- Exactly one outstanding burst; AW never precedes B completion of the previous burst.
- A burst never crosses a 4 KB boundary; AWADDR wraps modulo 2^ADDR_W.
- CMD_VALID while BUSY is ignored (CMD_READY=0).
- RST_N asserted mid-burst: immediate return to reset values. The partially consumed FIFO contents are the FIFO owner's concern; the FIFO is reset by the same reset.
- FIFO_RD_ENA never asserts when FIFO_RD_EMPTY=1.

Decomposition:
- Package aq_axi_sdma64_pkg holds the FSM state encoding and the constants AXSIZE_64=3'b011, BURST_INCR=2'b01, WSTRB_ALL=8'hFF, RESP_OKAY=2'b00 and BOUNDARY_4K=4096.
- One sub-module, aq_axi_sdma64_blen: combinational burst-length calculator (cur_addr, remain, MAX_BURST -> blen); unit-testable on its own.

Test Plan:
- CMD addr=0x1000, len=4, FIFO preloaded with 4 words, all READY=1 -> one AW (0x1000, AWLEN=3); W data in order; WLAST on beat 4; DONE pulse; ERR=0.
- addr=0x0, len=40, MAX_BURST=16 -> AW sequence 0x000/15, 0x080/15, 0x100/7; 40 pops; single DONE.
- addr=0x0FF0, len=4 -> bursts 0x0FF0/AWLEN=1 then 0x1000/AWLEN=1, no 4 KB crossing.
- FIFO empty for 5 cycles mid-burst with WREADY=1 -> WVALID=0 and FIFO_RD_ENA=0 during the gap; the beat sequence resumes intact.
- BRESP=2'b10 on the first of two bursts -> the second burst still issued; DONE pulses; ERR=1 held until the next CMD accept.
- len=0 -> no AWVALID, DONE one cycle after accept. RST_N pulsed low while in W -> all outputs at reset values; CMD_READY=1 after release.
